// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: controller state encoding,
// instruction addressing step and default parameter values.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RELEASE,
        ST_RUN,
        ST_ERR
    } loader_state_t;

    // Each instruction occupies two bytes of instruction memory.
    localparam int ADDR_STEP = 2;

    localparam int DEFAULT_ADDR_WIDTH     = 8;
    localparam int DEFAULT_INS_WIDTH      = 16;
    localparam int DEFAULT_RELEASE_CYCLES = 2;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/release_timer.sv
// Loadable down-counter that flags its final counting cycle; holds the core
// in reset for a fixed number of cycles after the last instruction write.
module release_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the reset here is synchronous, inside the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/program_loader.sv
// Boot/reload controller: streams instruction words into instruction memory at
// consecutive even addresses while holding the core in reset, then releases it.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int INS_WIDTH      = DEFAULT_INS_WIDTH,
    parameter int RELEASE_CYCLES = DEFAULT_RELEASE_CYCLES
) (
    input  logic                  clka,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [INS_WIDTH-1:0]  in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [INS_WIDTH-1:0]  imem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  err_overflow,
    output logic [ADDR_WIDTH-1:0] words_loaded
);

    localparam int PTR_W = ADDR_WIDTH - 1;
    localparam int CNT_W = cnt_width(RELEASE_CYCLES);

    loader_state_t         state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] words_q, words_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [INS_WIDTH-1:0]  wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic                  timer_load;
    logic                  timer_expired;

    release_timer #(
        .WIDTH (CNT_W)
    ) u_release_timer (
        .clk_i      (clka),
        .rst_i      (reset),
        .load_i     (timer_load),
        .load_val_i (CNT_W'(RELEASE_CYCLES)),
        .expired_o  (timer_expired)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        words_d    = words_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        timer_load = 1'b0;

        case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    words_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    we_d    = 1'b1;
                    addr_d  = ADDR_WIDTH'(ptr_q) * ADDR_WIDTH'(ADDR_STEP);
                    wdata_d = in_data;
                    words_d = words_q + ADDR_WIDTH'(1);
                    if (in_last) begin
                        state_d    = ST_RELEASE;
                        timer_load = 1'b1;
                        ptr_d      = ptr_q + PTR_W'(1);
                    end else if (ptr_q == '1) begin
                        // Final slot written without a terminator: the pointer
                        // is held rather than wrapped.
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
            end
            ST_RELEASE: begin
                if (timer_expired) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            words_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            words_q <= words_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign in_ready     = (state_q == ST_LOAD);
    assign busy         = (state_q == ST_LOAD) || (state_q == ST_RELEASE);
    assign done         = (state_q == ST_RUN);
    assign cpu_reset    = (state_q != ST_RUN);
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign err_overflow = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a default instance for load/release/reset
// sessions and a 4-bit-address instance for the overflow path.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        start, in_valid, in_last;
    logic [15:0] in_data;
    logic        in_ready, imem_we, cpu_reset, busy, done, err_overflow;
    logic [7:0]  imem_addr, words_loaded;
    logic [15:0] imem_wdata;

    logic        s_start, s_valid, s_last;
    logic [15:0] s_data;
    logic        s_in_ready, s_we, s_cpu_reset, s_busy, s_done, s_err;
    logic [3:0]  s_addr, s_words;
    logic [15:0] s_wdata;

    program_loader u_dut (
        .clka (clk), .reset (reset), .start (start), .in_valid (in_valid),
        .in_data (in_data), .in_last (in_last), .in_ready (in_ready),
        .imem_we (imem_we), .imem_addr (imem_addr), .imem_wdata (imem_wdata),
        .cpu_reset (cpu_reset), .busy (busy), .done (done),
        .err_overflow (err_overflow), .words_loaded (words_loaded)
    );

    program_loader #(.ADDR_WIDTH(4), .INS_WIDTH(16), .RELEASE_CYCLES(2)) u_small (
        .clka (clk), .reset (reset), .start (s_start), .in_valid (s_valid),
        .in_data (s_data), .in_last (s_last), .in_ready (s_in_ready),
        .imem_we (s_we), .imem_addr (s_addr), .imem_wdata (s_wdata),
        .cpu_reset (s_cpu_reset), .busy (s_busy), .done (s_done),
        .err_overflow (s_err), .words_loaded (s_words)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] sb[$];
    logic [31:0] sb_s[$];
    logic [15:0] prog [5] = '{16'h1028, 16'h1261, 16'h9240, 16'h1261, 16'h1001};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Write-port monitors: every write must match the oldest expected entry.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("main_unexpected_write", 32'(sb.size()), 32'd1);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("main_wr_addr", 32'(imem_addr), 32'(e[31:16]));
                chk("main_wr_data", 32'(imem_wdata), 32'(e[15:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (s_we === 1'b1) begin
            if (sb_s.size() == 0) begin
                chk("small_unexpected_write", 32'(sb_s.size()), 32'd1);
            end else begin
                logic [31:0] e;
                e = sb_s.pop_front();
                chk("small_wr_addr", 32'(s_addr), 32'(e[31:16]));
                chk("small_wr_data", 32'(s_wdata), 32'(e[15:0]));
            end
        end
    end

    task automatic do_start(input string tag);
        @(negedge clk); start = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk); start = 1'b0;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    // Called on the negedge where the last word is driven; checks the hold.
    task automatic release_check(input string tag, input int n_words);
        @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
        chk({tag, "_ready_off"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_words"}, 32'(words_loaded), 32'(n_words));
        chk({tag, "_hold1"}, 32'(cpu_reset), 32'd1);
        @(negedge clk);
        chk({tag, "_hold2"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_done_low"}, 32'(done), 32'd0);
        @(negedge clk);
        chk({tag, "_released"}, 32'(cpu_reset), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    endtask

    task automatic load5(input int gap);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = prog[i]; in_last = (i == 4);
            sb.push_back({16'(2 * i), prog[i]});
            if (i < 4) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    in_valid = 1'b0; in_data = 16'hDEAD;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        s_start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_err", 32'(err_overflow), 32'd0);
        chk("rst_small_cpu_reset", 32'(s_cpu_reset), 32'd1);
        reset = 1'b0;

        // Back-to-back stream.
        do_start("s1");
        load5(0);
        release_check("s1", 5);

        // Start from RUN, then the same stream with gaps in valid.
        do_start("s2");
        load5(1);
        release_check("s2", 5);

        // Single terminating word after a restart from RUN.
        do_start("s3");
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h0000; in_last = 1'b1;
        sb.push_back({16'd0, 16'h0000});
        release_check("s3", 1);

        // Reset in the middle of a session.
        do_start("s4");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 16'hA000 + 16'(i); in_last = 1'b0;
            sb.push_back({16'(2 * i), 16'hA000 + 16'(i)});
        end
        @(negedge clk);
        reset = 1'b1; in_data = 16'hBEEF;
        @(negedge clk);
        chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_we", 32'(imem_we), 32'd0);
        chk("mid_rst_addr", 32'(imem_addr), 32'd0);
        chk("mid_rst_wdata", 32'(imem_wdata), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_words", 32'(words_loaded), 32'd0);
        reset = 1'b0; in_valid = 1'b0;
        do_start("s5");
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'hABCD; in_last = 1'b1;
        sb.push_back({16'd0, 16'hABCD});
        release_check("s5", 1);

        // Overflow on the 4-bit address instance.
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        chk("ovf_ready", 32'(s_in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = 16'h5000 + 16'(i); s_last = 1'b0;
            sb_s.push_back({16'(2 * i), 16'h5000 + 16'(i)});
        end
        @(negedge clk);
        s_data = 16'hFFFF;
        chk("ovf_err", 32'(s_err), 32'd1);
        chk("ovf_ready_off", 32'(s_in_ready), 32'd0);
        chk("ovf_cpu_reset", 32'(s_cpu_reset), 32'd1);
        chk("ovf_words", 32'(s_words), 32'd8);
        chk("ovf_busy", 32'(s_busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("ovf_hold_cpu_reset", 32'(s_cpu_reset), 32'd1);
        chk("ovf_hold_err", 32'(s_err), 32'd1);
        s_valid = 1'b0; s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        chk("ovf_restart_err", 32'(s_err), 32'd0);
        chk("ovf_restart_ready", 32'(s_in_ready), 32'd1);
        chk("ovf_restart_words", 32'(s_words), 32'd0);
        @(negedge clk);
        s_valid = 1'b1; s_data = 16'h7777; s_last = 1'b1;
        sb_s.push_back({16'd0, 16'h7777});
        @(negedge clk); s_valid = 1'b0; s_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("ovf_reload_released", 32'(s_cpu_reset), 32'd0);
        chk("ovf_reload_done", 32'(s_done), 32'd1);

        repeat (2) @(negedge clk);
        chk("main_sb_drained", 32'(sb.size()), 32'd0);
        chk("small_sb_drained", 32'(sb_s.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot and reload controller for the 8-bit core. It accepts a stream of 16-bit instruction words over a valid/ready handshake and writes them into instruction memory at consecutive even byte addresses (0, 2, 4, …). It holds the core in reset while loading, then releases it to run from PC = 0. The block owns the instruction-memory write port and the core reset line, which removes any need for an external driver to sequence write-enable and reset by hand.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: instruction-memory byte-address width. Capacity is 2^(ADDR_WIDTH-1) words.
- `INS_WIDTH`, default 16: instruction word width.
- `RELEASE_CYCLES`, default 2: cycles `cpu_reset` is held after the final write, before release. Must be ≥1.

Ports:
- `clka`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  single-cycle request to begin a load session.
- `in_valid`  in  1  instruction word present.
- `in_data`  in  INS_WIDTH  instruction word.
- `in_last`  in  1  qualifies the final word of the session.
- `in_ready`  out  1  loader can accept a word.
- `imem_we`  out  1  instruction-memory write enable.
- `imem_addr`  out  ADDR_WIDTH  byte address of the write.
- `imem_wdata`  out  INS_WIDTH  write data.
- `cpu_reset`  out  1  core reset; high except in RUN.
- `busy`  out  1  state is LOAD or RELEASE.
- `done`  out  1  high in RUN.
- `err_overflow`  out  1  sticky; set when memory filled without `in_last`.
- `words_loaded`  out  ADDR_WIDTH  words accepted this session.

## Operation
- States: IDLE, LOAD, RELEASE, RUN, ERR.
- Reset values: state IDLE; `cpu_reset`=1; `in_ready`, `imem_we`, `busy`, `done`, `err_overflow`=0; `imem_addr`, `imem_wdata`, `words_loaded`=0; internal word pointer = 0.
- IDLE/RUN/ERR, `start`=1 → LOAD. Clears the pointer, `words_loaded` and `err_overflow`.
- LOAD: `in_ready`=1. A word is accepted when `in_valid` and `in_ready` are both high.
  - On accept: registered write (`imem_we`=1, `imem_addr`=pointer·2, `imem_wdata`=`in_data`); pointer+1; `words_loaded`+1.
- Accept with `in_last`=1 → RELEASE, release counter loaded with RELEASE_CYCLES.
- Accept without `in_last` at the final word slot (address 2^ADDR_WIDTH−2) → ERR. `err_overflow`=1; the write still occurs.
- RELEASE: `in_ready`=0; counter decrements each cycle; at 1 → RUN.
- RUN: `cpu_reset`=0, `done`=1.
- ERR: `cpu_reset`=1, `in_ready`=0; only `start` or `reset` exits.
- `start` in LOAD or RELEASE is ignored.
- `in_valid` while `in_ready`=0 is ignored; the word is not consumed.
- `reset` mid-session aborts it. Words already written remain in memory; outputs return to reset values.
- Pointer arithmetic is unsigned, ADDR_WIDTH−1 bits. It never wraps, because ERR catches the full condition.

## Timing
- `start` sampled at edge t → `in_ready`=1 from t+1. `in_ready` is a Moore output of the state.
- Accept at edge k → `imem_we`/`imem_addr`/`imem_wdata` valid in cycle k+1, one cycle wide.
  - Back-to-back accepts give back-to-back writes at addresses +2 apart.
- Last accept at edge k → `in_ready`=0 from k+1.
  - `cpu_reset` stays high through k+RELEASE_CYCLES.
  - `cpu_reset` falls and `done` rises at k+1+RELEASE_CYCLES.
  - The last write always precedes release.
- `start` in RUN at edge t → `cpu_reset`=1 and `done`=0 at t+1.
- `err_overflow` rises in the cycle after the overflowing accept, together with that word's write.

## Structure
- Package `loader_pkg`:
  - state enum `loader_state_t`;
  - `ADDR_STEP`=2 (bytes per instruction);
  - default parameter constants.
- One sub-module, `release_timer`: a loadable down-counter with a `expired` flag, parameterised by width, used for the RELEASE hold.
- Datapath registers (pointer, write-port registers, counters) live in `program_loader`.

## Test plan
- Reset for 2 cycles → `cpu_reset`=1, `in_ready`=0, `imem_we`=0, `done`=0, `words_loaded`=0.
- `start`; stream 0x1028, 0x1261, 0x9240, 0x1261, 0x1001 (last on 0x1001), valid every cycle:
  - five writes, one per cycle, at addresses 0, 2, 4, 6, 8 with matching data;
  - `words_loaded`=5;
  - `cpu_reset` falls exactly 3 cycles after the final accept (RELEASE_CYCLES=2).
- Same stream with `in_valid` dropped every other cycle → same addresses and data, no duplicate or skipped writes.
- ADDR_WIDTH=4, 8 words with no `in_last`:
  - 8th write at address 14;
  - ERR entered, `err_overflow`=1;
  - `cpu_reset` stays 1;
  - a following `start` clears the error and reloads from address 0.
- `start` in RUN, then a single word 0x0000 with `in_last` → `cpu_reset` rises next cycle; one write at address 0; release after RELEASE_CYCLES.
- `reset` asserted in LOAD after 2 accepts → all outputs at reset values next cycle; a later `start` begins writing at address 0.
